// File: rtl/mixer_pkg.sv
// Shared types and helpers for the layer mixer.
// Priority is lowest index first.
package mixer_pkg;

  localparam int RGB_W      = 24;
  localparam int X_W        = 10;
  localparam int Y_W        = 9;
  localparam int MAX_LAYERS = 32;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    REPORT
  } probe_state_t;

  function automatic logic [4:0] prio_index(
    input logic [MAX_LAYERS-1:0] mask
  );
    prio_index = '0;
    for (int i = MAX_LAYERS - 1; i >= 0; i--)
      if (mask[i]) prio_index = 5'(i);
  endfunction

endpackage

// File: rtl/hit_probe.sv
// Shot probe: latches a target pixel, watches the scan for it
// and reports which enabled layers were drawn there.
module hit_probe
  import mixer_pkg::*;
#(
  parameter int NUM_LAYERS     = 4,
  parameter int WIDTH          = 640,
  parameter int HEIGHT         = 480,
  parameter int TIMEOUT_FRAMES = 2,
  parameter int LW             = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_LAYERS-1:0] eff,
  input  logic [X_W-1:0]        x,
  input  logic [Y_W-1:0]        y,
  input  logic                  shot,
  input  logic [X_W-1:0]        shoot_x,
  input  logic [Y_W-1:0]        shoot_y,
  output logic                  busy,
  output logic                  hit_valid,
  output logic [NUM_LAYERS-1:0] hit_mask,
  output logic [LW-1:0]         hit_layer,
  output logic                  miss
);

  localparam int CW = $clog2(TIMEOUT_FRAMES + 1);

  probe_state_t          r_state;
  logic [X_W-1:0]        r_sx;
  logic [Y_W-1:0]        r_sy;
  logic [CW-1:0]         r_frames;
  logic                  r_at0;
  logic [NUM_LAYERS-1:0] r_mask;
  logic [LW-1:0]         r_layer;
  logic                  r_miss;

  logic                  w_at0;
  logic                  w_fs;
  logic                  w_oob;
  logic                  w_match;
  logic                  w_tout;
  logic                  w_done;
  logic                  w_miss;
  logic [NUM_LAYERS-1:0] w_cap;

  assign w_at0   = (x == '0) && (y == '0);
  assign w_fs    = w_at0 && !r_at0;
  assign w_match = (x == r_sx) && (y == r_sy);
  assign w_tout  = r_frames == CW'(TIMEOUT_FRAMES - 1);
  assign w_oob   = (32'(r_sx) >= 32'(WIDTH))
                || (32'(r_sy) >= 32'(HEIGHT));

  // The scan passes through blanking columns, so an off-screen
  // target must be rejected before it can ever "match".
  always_comb begin
    w_done = 1'b0;
    w_miss = 1'b0;
    w_cap  = '0;
    if (r_state == ARMED) begin
      if (w_oob) begin
        w_done = 1'b1;
        w_miss = 1'b1;
      end else if (w_match) begin
        w_done = 1'b1;
        w_cap  = eff;
      end else if (w_fs && w_tout) begin
        w_done = 1'b1;
        w_miss = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_sx     <= '0;
      r_sy     <= '0;
      r_frames <= '0;
      r_at0    <= 1'b0;
      r_mask   <= '0;
      r_layer  <= '0;
      r_miss   <= 1'b0;
    end else begin
      r_at0 <= w_at0;
      unique case (r_state)
        IDLE: begin
          if (shot) begin
            r_sx     <= shoot_x;
            r_sy     <= shoot_y;
            r_frames <= '0;
            r_state  <= ARMED;
          end
        end
        ARMED: begin
          if (w_done) begin
            r_state <= REPORT;
            r_mask  <= w_cap;
            r_miss  <= w_miss;
            r_layer <= LW'(prio_index(MAX_LAYERS'(w_cap)));
          end else if (w_fs) begin
            r_frames <= r_frames + CW'(1);
          end
        end
        REPORT:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_state != IDLE;
  assign hit_valid = r_state == REPORT;
  assign hit_mask  = r_mask;
  assign hit_layer = r_layer;
  assign miss      = r_miss;

endmodule

// File: rtl/layer_mixer.sv
// Fixed-priority layer compositor with registered RGB output
// and a shot hit-probe sampling the same effective flags.
module layer_mixer
  import mixer_pkg::*;
#(
  parameter int              NUM_LAYERS     = 4,
  parameter int              WIDTH          = 640,
  parameter int              HEIGHT         = 480,
  parameter logic [RGB_W-1:0] BG_RGB        = 24'h000000,
  parameter int              TIMEOUT_FRAMES = 2,
  localparam int             LW = (NUM_LAYERS > 1)
                                ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [X_W-1:0]                   x,
  input  logic [Y_W-1:0]                   y,
  input  logic [NUM_LAYERS-1:0]            layer_render,
  input  logic [NUM_LAYERS-1:0]            layer_en,
  input  logic [NUM_LAYERS-1:0][RGB_W-1:0] layer_rgb,
  input  logic                             shot,
  input  logic [X_W-1:0]                   shoot_x,
  input  logic [Y_W-1:0]                   shoot_y,
  output logic [7:0]                       r,
  output logic [7:0]                       g,
  output logic [7:0]                       b,
  output logic                             busy,
  output logic                             hit_valid,
  output logic [NUM_LAYERS-1:0]            hit_mask,
  output logic [LW-1:0]                    hit_layer,
  output logic                             miss
);

  logic [NUM_LAYERS-1:0] w_eff;
  logic [LW-1:0]         w_idx;
  logic [RGB_W-1:0]      w_rgb;
  logic [RGB_W-1:0]      r_rgb;

  assign w_eff = layer_render & layer_en;
  assign w_idx = LW'(prio_index(MAX_LAYERS'(w_eff)));
  assign w_rgb = (|w_eff) ? layer_rgb[w_idx] : BG_RGB;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rgb <= '0;
    else          r_rgb <= w_rgb;
  end

  assign r = r_rgb[23:16];
  assign g = r_rgb[15:8];
  assign b = r_rgb[7:0];

  hit_probe #(
    .NUM_LAYERS     (NUM_LAYERS),
    .WIDTH          (WIDTH),
    .HEIGHT         (HEIGHT),
    .TIMEOUT_FRAMES (TIMEOUT_FRAMES),
    .LW             (LW)
  ) u_probe (
    .clk       (clk),
    .reset_n   (reset_n),
    .eff       (w_eff),
    .x         (x),
    .y         (y),
    .shot      (shot),
    .shoot_x   (shoot_x),
    .shoot_y   (shoot_y),
    .busy      (busy),
    .hit_valid (hit_valid),
    .hit_mask  (hit_mask),
    .hit_layer (hit_layer),
    .miss      (miss)
  );

endmodule

// File: tb/tb_layer_mixer.sv
// Scoreboard bench for layer_mixer: event-level reference model
// feeding pixel and hit-report queues checked by a monitor.
module tb_layer_mixer;

  localparam int NL = 4;
  localparam int W  = 640;
  localparam int H  = 480;
  localparam int TO = 2;
  localparam logic [23:0] BG = 24'h000000;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [9:0]             x;
  logic [8:0]             y;
  logic [NL-1:0]          layer_render;
  logic [NL-1:0]          layer_en;
  logic [NL-1:0][23:0]    layer_rgb;
  logic                   shot;
  logic [9:0]             shoot_x;
  logic [8:0]             shoot_y;
  logic [7:0]             r, g, b;
  logic                   busy, hit_valid, miss;
  logic [NL-1:0]          hit_mask;
  logic [1:0]             hit_layer;

  always #5 clk = ~clk;

  layer_mixer #(
    .NUM_LAYERS     (NL),
    .WIDTH          (W),
    .HEIGHT         (H),
    .BG_RGB         (BG),
    .TIMEOUT_FRAMES (TO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .x            (x),
    .y            (y),
    .layer_render (layer_render),
    .layer_en     (layer_en),
    .layer_rgb    (layer_rgb),
    .shot         (shot),
    .shoot_x      (shoot_x),
    .shoot_y      (shoot_y),
    .r            (r),
    .g            (g),
    .b            (b),
    .busy         (busy),
    .hit_valid    (hit_valid),
    .hit_mask     (hit_mask),
    .hit_layer    (hit_layer),
    .miss         (miss)
  );

  typedef struct {
    logic [23:0] rgb;
    bit          busy;
  } pix_t;

  typedef struct {
    logic [NL-1:0] mask;
    int            layer;
    bit            miss;
    int            at;
  } hit_t;

  pix_t pixq[$];
  hit_t hitq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic [NL-1:0][23:0] rgb_cfg;

  // reference probe: one outstanding target at a time
  bit p_act, p_oob, prev0;
  int p_tx, p_ty, p_start, p_fs, accept_at;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [NL-1:0] m);
    for (int i = 0; i < NL; i++)
      if (m[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    pixq.delete();
    hitq.delete();
    p_act     = 0;
    prev0     = 0;
    accept_at = 0;
  endtask

  task automatic step(input logic [NL-1:0] rend,
                      input logic [NL-1:0] en,
                      input int xx, input int yy,
                      input bit sh,
                      input int sx, input int sy);
    logic [NL-1:0] eff;
    logic [23:0]   col;
    bit            at0, fs, done;
    int            t;
    hit_t          h;
    pix_t          p;
    @(negedge clk);
    t            = cyc;
    layer_rgb    = rgb_cfg;
    layer_render = rend;
    layer_en     = en;
    x            = 10'(xx);
    y            = 9'(yy);
    shot         = sh;
    shoot_x      = 10'(sx);
    shoot_y      = 9'(sy);
    eff = rend & en;
    col = BG;
    for (int i = NL - 1; i >= 0; i--)
      if (eff[i]) col = rgb_cfg[i];
    at0   = (xx == 0) && (yy == 0);
    fs    = at0 && !prev0;
    prev0 = at0;
    done  = 0;
    h     = '{mask: '0, layer: 0, miss: 0, at: 0};
    if (p_act && t > p_start) begin
      if (p_oob) begin
        h.miss = 1; done = 1;
      end else if (xx == p_tx && yy == p_ty) begin
        h.mask = eff; done = 1;
      end else if (fs) begin
        p_fs++;
        if (p_fs == TO) begin
          h.miss = 1; done = 1;
        end
      end
    end
    if (done) begin
      h.layer   = lowest(h.mask);
      h.at      = t + 1;
      hitq.push_back(h);
      p_act     = 0;
      accept_at = t + 2;
    end
    if (sh && !p_act && t >= accept_at) begin
      p_act   = 1;
      p_start = t;
      p_tx    = sx;
      p_ty    = sy;
      p_oob   = (sx >= W) || (sy >= H);
      p_fs    = 0;
    end
    p.rgb  = col;
    p.busy = p_act || done;
    pixq.push_back(p);
  endtask

  task automatic idle(input int n, input int xx, input int yy);
    for (int i = 0; i < n; i++)
      step('0, '1, xx, yy, 0, 0, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rgb"},  {8'h0, r, g, b}, 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_hv"},   32'(hit_valid), 32'h0);
    chk({tag, "_mask"}, 32'(hit_mask), 32'h0);
    chk({tag, "_lyr"},  32'(hit_layer), 32'h0);
    chk({tag, "_miss"}, 32'(miss), 32'h0);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_zero("midrst");
    model_reset();
    shot = 1'b0;
    x    = 10'd5;
    y    = 9'd5;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // monitor
  initial forever begin
    pix_t p;
    hit_t h;
    @(posedge clk);
    cyc++;
    #1;
    if (reset_n) begin
      if (pixq.size() > 0) begin
        p = pixq.pop_front();
        chk("pix_rgb", {8'h0, r, g, b}, {8'h0, p.rgb});
        chk("busy", 32'(busy), 32'(p.busy));
      end
      while (hitq.size() > 0 && hitq[0].at < cyc) begin
        h = hitq.pop_front();
        chk("hit_missing_at", 32'(cyc), 32'(h.at));
      end
      if (hit_valid) begin
        if (hitq.size() == 0) begin
          chk("hit_unexpected", 32'(hit_valid), 32'h0);
        end else begin
          h = hitq.pop_front();
          chk("hit_cycle", 32'(cyc), 32'(h.at));
          chk("hit_mask", 32'(hit_mask), 32'(h.mask));
          chk("hit_layer", 32'(hit_layer), 32'(h.layer));
          chk("hit_miss", 32'(miss), 32'(h.miss));
        end
      end
    end
  end

  initial begin
    int rx, ry, sx, sy;
    bit sh;
    reset_n      = 1'b0;
    x            = '0;
    y            = '0;
    shot         = 1'b0;
    shoot_x      = '0;
    shoot_y      = '0;
    layer_render = '0;
    layer_en     = '0;
    for (int i = 0; i < NL; i++) rgb_cfg[i] = 24'($urandom);
    layer_rgb = rgb_cfg;
    model_reset();
    #12 chk_zero("rst");
    @(negedge clk);
    x = 10'd5;
    y = 9'd5;
    reset_n = 1'b1;

    rgb_cfg[0] = 24'h0000FF;
    rgb_cfg[1] = 24'hFF0000;
    rgb_cfg[2] = 24'h123456;
    rgb_cfg[3] = 24'h00FF00;
    step(4'b1010, 4'b1111, 3, 3, 0, 0, 0);
    step(4'b0000, 4'b1111, 3, 4, 0, 0, 0);
    step(4'b0001, 4'b1110, 4, 4, 0, 0, 0);

    // disabled layer at probe pixel: empty mask, not a miss
    step('0, '1, 7, 7, 1, 20, 10);
    step('0, '1, 1, 1, 0, 0, 0);
    step(4'b0001, 4'b1110, 20, 10, 0, 0, 0);
    idle(3, 2, 2);

    // hit in next frame
    step('0, '1, 5, 5, 1, 100, 50);
    idle(3, 6, 1);
    idle(1, 0, 0);
    idle(2, 1, 0);
    step(4'b0100, '1, 100, 50, 0, 0, 0);
    idle(3, 2, 2);

    // off-screen
    step('0, '1, 5, 5, 1, 700, 50);
    idle(4, 3, 3);
    step('0, '1, 5, 5, 1, 10, 490);
    idle(4, 3, 3);

    // timeout over two frame starts
    step('0, '1, 9, 9, 1, 30, 30);
    idle(1, 0, 0);
    idle(3, 1, 0);
    idle(1, 0, 0);
    idle(3, 4, 4);

    // second shot while armed is dropped
    step('0, '1, 5, 5, 1, 100, 50);
    step('0, '1, 3, 3, 1, 10, 10);
    step(4'b1111, '1, 10, 10, 0, 0, 0);
    step(4'b0010, '1, 100, 50, 0, 0, 0);
    idle(3, 2, 2);

    // reset abandons an armed probe
    step('0, '1, 5, 5, 1, 200, 100);
    idle(2, 6, 6);
    reset_mid();
    step(4'b1111, '1, 200, 100, 0, 0, 0);
    idle(3, 2, 2);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 63) == 0)
        for (int i = 0; i < NL; i++) rgb_cfg[i] = 24'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        rx = 0; ry = 0;
      end else begin
        rx = $urandom_range(0, 3);
        ry = $urandom_range(0, 3);
      end
      sh = ($urandom_range(0, 15) == 0);
      sx = $urandom_range(0, 3);
      sy = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) sx = $urandom_range(640, 700);
      if ($urandom_range(0, 15) == 0) sy = $urandom_range(480, 511);
      step(4'($urandom), 4'($urandom), rx, ry, sh, sx, sy);
    end

    idle(6, 2, 2);
    @(posedge clk);
    #2;
    while (hitq.size() > 0) begin
      hit_t h;
      h = hitq.pop_front();
      chk("hit_never_seen", 32'(cyc), 32'(h.at));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
